// File: rtl/ex_lsu_pkg.sv
// Shared definitions for the execute-stage load/store unit: RV32I memory
// funct3 encodings and the transaction FSM state type.
package ex_lsu_pkg;

    // Load encodings (lsu_we_i = 0)
    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;

    // Store encodings (lsu_we_i = 1)
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    // One bus transaction: idle, request until granted, wait for response
    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT
    } lsu_state_t;

endpackage

// File: rtl/ex_lsu_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
// Signal suffixes are written from the load/store unit's point of view.
interface ex_lsu_if #(
    parameter int XLEN = 32
);
    logic            dbus_req_o;
    logic            dbus_we_o;
    logic [3:0]      dbus_be_o;
    logic [XLEN-1:0] dbus_addr_o;
    logic [XLEN-1:0] dbus_wdata_o;
    logic            dbus_gnt_i;
    logic            dbus_rvalid_i;
    logic [XLEN-1:0] dbus_rdata_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o,
        input  dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );

    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o,
        output dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
    );
endinterface

// File: rtl/ex_lsu_align.sv
// Purely combinational lane logic for the load/store unit: decodes the
// incoming op, flags misalignment, builds byte enables and replicated store
// data, and extracts/extends returning load data.
module ex_lsu_align
    import ex_lsu_pkg::*;
(
    // request side (live inputs from EX)
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addrOff_i,
    input  logic [31:0] wdata_i,
    output logic        opValid_o,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    // response side (registered op attributes plus bus read data)
    input  logic [2:0]  ldFunct3_i,
    input  logic [1:0]  ldOff_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldData_o
);

    logic [31:0] shifted;

    // Request decode: legality, alignment, byte enables and store lanes
    always_comb begin
        opValid_o  = 1'b0;
        misalign_o = 1'b0;
        be_o       = 4'b1111;
        wdata_o    = '0;
        if (we_i) begin
            case (funct3_i)
                LSU_SB: begin
                    opValid_o = 1'b1;
                    be_o      = 4'b0001 << addrOff_i;
                    wdata_o   = {4{wdata_i[7:0]}};
                end
                LSU_SH: begin
                    opValid_o  = 1'b1;
                    misalign_o = addrOff_i[0];
                    be_o       = 4'b0011 << addrOff_i;
                    wdata_o    = {2{wdata_i[15:0]}};
                end
                LSU_SW: begin
                    opValid_o  = 1'b1;
                    misalign_o = |addrOff_i;
                    wdata_o    = wdata_i;
                end
                default: ;
            endcase
        end else begin
            case (funct3_i)
                LSU_LB, LSU_LBU: opValid_o = 1'b1;
                LSU_LH, LSU_LHU: begin
                    opValid_o  = 1'b1;
                    misalign_o = addrOff_i[0];
                end
                LSU_LW: begin
                    opValid_o  = 1'b1;
                    misalign_o = |addrOff_i;
                end
                default: ;
            endcase
        end
    end

    // Load extraction: shift the addressed byte/half to lane 0, then extend
    always_comb begin
        shifted = rdata_i >> {ldOff_i, 3'b000};
        case (ldFunct3_i)
            LSU_LB:  ldData_o = {{24{shifted[7]}}, shifted[7:0]};
            LSU_LBU: ldData_o = {24'b0, shifted[7:0]};
            LSU_LH:  ldData_o = {{16{shifted[15]}}, shifted[15:0]};
            LSU_LHU: ldData_o = {16'b0, shifted[15:0]};
            default: ldData_o = shifted;
        endcase
    end

endmodule

// File: rtl/ex_lsu.sv
// Execute-stage load/store unit. Accepts one memory op at a time in IDLE,
// drives a registered req/gnt/rvalid bus transaction, stalls the pipeline
// until the response arrives, and returns extended load data.
module ex_lsu
    import ex_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [2:0]      lsu_funct3_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_stall_o,
    output logic            lsu_done_o,
    output logic            lsu_rd_valid_o,
    output logic [XLEN-1:0] lsu_rd_data_o,
    output logic            lsu_misalign_o,
    ex_lsu_if.master        dbus
);

    lsu_state_t  state_q, state_d;
    logic [29:0] wordAddr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] rdData_q;

    logic        opValid;
    logic        opMisalign;
    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic [31:0] ldData;

    logic        accept;
    logic        stall;
    logic        misalign;
    logic        done;
    logic        rdValid;

    ex_lsu_align u_align (
        .we_i       (lsu_we_i),
        .funct3_i   (lsu_funct3_i),
        .addrOff_i  (lsu_addr_i[1:0]),
        .wdata_i    (lsu_wdata_i),
        .opValid_o  (opValid),
        .misalign_o (opMisalign),
        .be_o       (alignBe),
        .wdata_o    (alignWdata),
        .ldFunct3_i (funct3_q),
        .ldOff_i    (off_q),
        .rdata_i    (dbus.dbus_rdata_i),
        .ldData_o   (ldData)
    );

    // Next-state and per-cycle handshake decode
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        done     = 1'b0;
        rdValid  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (lsu_req_i && opValid) begin
                    if (opMisalign) begin
                        misalign = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                stall = 1'b1;
                if (dbus.dbus_gnt_i) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (dbus.dbus_rvalid_i) begin
                    done    = 1'b1;
                    rdValid = ~we_q;
                    state_d = LSU_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the accepted op so the bus sees stable values until granted
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wordAddr_q <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
        end else if (accept) begin
            wordAddr_q <= lsu_addr_i[31:2];
            be_q       <= alignBe;
            wdata_q    <= alignWdata;
            we_q       <= lsu_we_i;
            funct3_q   <= lsu_funct3_i;
            off_q      <= lsu_addr_i[1:0];
        end
    end

    // Last completed load result, held between loads
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdData_q <= '0;
        end else if (rdValid) begin
            rdData_q <= ldData;
        end
    end

    // The IDLE-state terms depend on live inputs, so they are masked while
    // reset is asserted to keep every output at zero during reset.
    assign lsu_stall_o    = stall & rst_n_i;
    assign lsu_misalign_o = misalign & rst_n_i;
    assign lsu_done_o     = done;
    assign lsu_rd_valid_o = rdValid;
    assign lsu_rd_data_o  = rdValid ? ldData : rdData_q;

    assign dbus.dbus_req_o   = (state_q == LSU_REQ);
    assign dbus.dbus_we_o    = we_q;
    assign dbus.dbus_be_o    = be_q;
    assign dbus.dbus_addr_o  = {wordAddr_q, 2'b00};
    assign dbus.dbus_wdata_o = wdata_q;

endmodule

// File: tb/tb_ex_lsu.sv
// Scoreboard testbench for ex_lsu: stimulus tasks push the expected
// completion of each op into a queue, and an independent monitor pops and
// compares whenever the unit reports a completion or a misalign pulse.
module tb_ex_lsu;

   // Response kinds held in the scoreboard
   localparam int KIND_LOAD     = 0;
   localparam int KIND_STORE    = 1;
   localparam int KIND_MISALIGN = 2;

   typedef struct {
      int          kind;
      logic [31:0] rdData;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        lsuReq;
   logic        lsuWe;
   logic [2:0]  lsuFunct3;
   logic [31:0] lsuAddr;
   logic [31:0] lsuWdata;
   logic        lsuStall;
   logic        lsuDone;
   logic        lsuRdValid;
   logic [31:0] lsuRdData;
   logic        lsuMisalign;

   exp_t sbQ[$];
   int   compared   = 0;
   int   mismatched = 0;

   ex_lsu_if #(.XLEN(32)) busIf ();

   ex_lsu #(.XLEN(32)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .lsu_req_i      (lsuReq),
      .lsu_we_i       (lsuWe),
      .lsu_funct3_i   (lsuFunct3),
      .lsu_addr_i     (lsuAddr),
      .lsu_wdata_i    (lsuWdata),
      .lsu_stall_o    (lsuStall),
      .lsu_done_o     (lsuDone),
      .lsu_rd_valid_o (lsuRdValid),
      .lsu_rd_data_o  (lsuRdData),
      .lsu_misalign_o (lsuMisalign),
      .dbus           (busIf)
   );

   // 10-unit clock; inputs change 1 unit after the rising edge, outputs are
   // sampled on the falling edge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done/misalign/rd_valid pulse must match the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (lsuDone || lsuMisalign || lsuRdValid)) begin
            if (sbQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_response: done=%0b misalign=%0b rd_valid=%0b, expected no response",
                        lsuDone, lsuMisalign, lsuRdValid);
            end else begin
               e = sbQ.pop_front();
               checkOutput("mon_done",     32'(lsuDone),     32'(e.kind != KIND_MISALIGN));
               checkOutput("mon_misalign", 32'(lsuMisalign), 32'(e.kind == KIND_MISALIGN));
               checkOutput("mon_rd_valid", 32'(lsuRdValid),  32'(e.kind == KIND_LOAD));
               if (e.kind == KIND_LOAD) begin
                  checkOutput("mon_rd_data", lsuRdData, e.rdData);
               end
            end
         end
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One full transaction: accept, gntWait ungranted REQ cycles, granting cycle,
   // waitIdle WAIT cycles without rvalid, then either the rvalid cycle or a
   // reset abort. Bus outputs are checked against hand-computed values in REQ.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int gntWait, input int waitIdle,
                                input logic [31:0] rdata, input logic [31:0] expAddr,
                                input logic [3:0] expBe, input logic [31:0] expWdata,
                                input logic [31:0] expRd, input bit glitch, input bit abort);
      exp_t e;
      lsuReq    = 1'b1;
      lsuWe     = we;
      lsuFunct3 = f3;
      lsuAddr   = addr;
      lsuWdata  = wdata;
      e.kind    = we ? KIND_STORE : KIND_LOAD;
      e.rdData  = expRd;
      sbQ.push_back(e);
      @(negedge clk);
      checkOutput("accept_stall",   32'(lsuStall),          32'd1);
      checkOutput("accept_bus_req", 32'(busIf.dbus_req_o),  32'd0);
      @(posedge clk); #1;
      for (int i = 0; i <= gntWait; i++) begin
         busIf.dbus_gnt_i    = (i == gntWait);
         busIf.dbus_rvalid_i = glitch && (i == 0);
         busIf.dbus_rdata_i  = 32'hBAD0_BAD0;
         @(negedge clk);
         checkOutput("req_stall", 32'(lsuStall),            32'd1);
         checkOutput("req_valid", 32'(busIf.dbus_req_o),    32'd1);
         checkOutput("req_addr",  busIf.dbus_addr_o,        expAddr);
         checkOutput("req_be",    32'(busIf.dbus_be_o),     32'(expBe));
         checkOutput("req_wdata", busIf.dbus_wdata_o,       expWdata);
         checkOutput("req_we",    32'(busIf.dbus_we_o),     32'(we));
         @(posedge clk); #1;
      end
      busIf.dbus_gnt_i    = 1'b0;
      busIf.dbus_rvalid_i = 1'b0;
      for (int i = 0; i < waitIdle; i++) begin
         @(negedge clk);
         checkOutput("wait_stall",   32'(lsuStall),         32'd1);
         checkOutput("wait_bus_req", 32'(busIf.dbus_req_o), 32'd0);
         @(posedge clk); #1;
      end
      if (abort) begin
         #2;
         lsuReq = 1'b0;
         rst_n  = 1'b0;
         sbQ.delete();
         #1;
         checkOutput("rst_stall",     32'(lsuStall),           32'd0);
         checkOutput("rst_done",      32'(lsuDone),            32'd0);
         checkOutput("rst_rd_valid",  32'(lsuRdValid),         32'd0);
         checkOutput("rst_rd_data",   lsuRdData,               32'd0);
         checkOutput("rst_bus_req",   32'(busIf.dbus_req_o),   32'd0);
         checkOutput("rst_bus_be",    32'(busIf.dbus_be_o),    32'd0);
         checkOutput("rst_bus_addr",  busIf.dbus_addr_o,       32'd0);
         checkOutput("rst_bus_wdata", busIf.dbus_wdata_o,      32'd0);
         checkOutput("rst_bus_we",    32'(busIf.dbus_we_o),    32'd0);
      end else begin
         busIf.dbus_rvalid_i = 1'b1;
         busIf.dbus_rdata_i  = rdata;
         @(negedge clk);
         checkOutput("resp_stall", 32'(lsuStall), 32'd0);
         @(posedge clk); #1;
         busIf.dbus_rvalid_i = 1'b0;
         busIf.dbus_rdata_i  = 32'h0;
         lsuReq              = 1'b0;
      end
   endtask

   // Ops that must be refused without touching the bus or stalling
   task automatic applyReject(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input bit expMisalign);
      exp_t e;
      lsuReq    = 1'b1;
      lsuWe     = we;
      lsuFunct3 = f3;
      lsuAddr   = addr;
      lsuWdata  = 32'hFFFF_FFFF;
      if (expMisalign) begin
         e.kind   = KIND_MISALIGN;
         e.rdData = 32'h0;
         sbQ.push_back(e);
      end
      @(negedge clk);
      checkOutput("reject_stall",   32'(lsuStall),         32'd0);
      checkOutput("reject_bus_req", 32'(busIf.dbus_req_o), 32'd0);
      @(posedge clk); #1;
      lsuReq = 1'b0;
      @(negedge clk);
      checkOutput("reject_after_bus_req", 32'(busIf.dbus_req_o), 32'd0);
      @(posedge clk); #1;
   endtask

   // Directed sequence with hand-computed expectations
   initial begin
      rst_n               = 1'b0;
      lsuReq              = 1'b0;
      lsuWe               = 1'b0;
      lsuFunct3           = 3'b000;
      lsuAddr             = 32'h0;
      lsuWdata            = 32'h0;
      busIf.dbus_gnt_i    = 1'b0;
      busIf.dbus_rvalid_i = 1'b0;
      busIf.dbus_rdata_i  = 32'h0;
      repeat (2) @(negedge clk);
      checkOutput("init_stall",    32'(lsuStall),         32'd0);
      checkOutput("init_bus_req",  32'(busIf.dbus_req_o), 32'd0);
      checkOutput("init_rd_data",  lsuRdData,             32'd0);
      checkOutput("init_misalign", 32'(lsuMisalign),      32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LW 0x1000 at minimum latency
      applyStimulus(1'b0, 3'b010, 32'h0000_1000, 32'h0, 0, 0, 32'hDEAD_BEEF,
                    32'h0000_1000, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      // LB / LBU at byte 3 of 0x80FF0000
      applyStimulus(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_0000,
                    32'h0000_1000, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b100, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_0000,
                    32'h0000_1000, 4'b1111, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
      // SH to the upper half; load result register must hold 0x80
      applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 32'h0,
                    32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("rd_data_hold", lsuRdData, 32'h0000_0080);
      @(posedge clk); #1;
      // Misaligned and illegal ops
      applyReject(1'b0, 3'b010, 32'h0000_1002, 1'b1);
      applyReject(1'b1, 3'b001, 32'h0000_2001, 1'b1);
      applyReject(1'b0, 3'b011, 32'h0000_1000, 1'b0);
      applyReject(1'b1, 3'b100, 32'h0000_1000, 1'b0);
      // SW with 5 ungranted cycles, 3 idle WAIT cycles, rvalid glitch in REQ
      applyStimulus(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 5, 3, 32'h0,
                    32'h0000_3004, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0);
      // Halfword loads and a byte store/load in lane 1
      applyStimulus(1'b0, 3'b001, 32'h0000_1002, 32'h0, 1, 1, 32'h8001_1234,
                    32'h0000_1000, 4'b1111, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b101, 32'h0000_1002, 32'h0, 0, 0, 32'h8001_1234,
                    32'h0000_1000, 4'b1111, 32'h0, 32'h0000_8001, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 0, 0, 32'h0,
                    32'h0000_1000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'b000, 32'h0000_1001, 32'h0, 0, 0, 32'h0000_7F00,
                    32'h0000_1000, 4'b1111, 32'h0, 32'h0000_007F, 1'b0, 1'b0);
      // Reset while waiting for the response, then a normal LW
      applyStimulus(1'b0, 3'b010, 32'h0000_1008, 32'h0, 0, 2, 32'h0,
                    32'h0000_1008, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_stall", 32'(lsuStall), 32'd0);
      @(posedge clk); #1;
      applyStimulus(1'b0, 3'b010, 32'h0000_1004, 32'h0, 0, 0, 32'h0123_4567,
                    32'h0000_1004, 4'b1111, 32'h0, 32'h0123_4567, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
